uart_rx_engine: RTL

Asynchronous-serial receiver and the receive-side counterpart of the UART transmit path. It synchronizes the `rx` line, qualifies the start bit at mid-bit, and samples a 7- or 8-bit data frame with optional parity at the centre of each bit. It presents the received byte with ready, parity-error, framing-error and overrun flags to the register interface, which clears them with a read strobe.

---
 rtl/uart_rx_engine.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_rx_engine.sv
// Asynchronous-serial receiver: 2-flop synchronizer, mid-bit start qualification,
// centre-of-bit sampling of a 7/8-bit frame with optional parity and one stop bit.
module uart_rx_engine #(
  parameter int BAUD_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic [BAUD_W-1:0] baud_k,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic              rd,
  output logic [7:0]        rx_data,
  output logic              rxrdy,
  output logic              perr,
  output logic              ferr,
  output logic              ovf
);

  typedef enum logic [2:0] {IDLE, START, SHIFT, DONE, BRK} state_t;

  typedef struct packed {
    logic [BAUD_W-1:0] k;
    logic              eight;
    logic              pen;
    logic              ohel;
  } cfg_t;

  state_t            state;
  cfg_t              cfg;
  logic [1:0]        sync;
  logic              rx_s;
  logic [BAUD_W-1:0] cnt;
  logic [3:0]        bcnt;
  logic [9:0]        sh;

  logic       btu;
  logic [3:0] n_bits;
  logic [3:0] par_idx;
  logic [7:0] data;
  logic       par_bit;
  logic       stop_bit;
  logic       perr_n;

  assign rx_s = sync[1];

  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rx};

  // Samples are stored by bit position so parity and stop fall at known indices.
  assign n_bits   = 4'd8 + {3'b0, cfg.eight} + {3'b0, cfg.pen};
  assign par_idx  = 4'd7 + {3'b0, cfg.eight};
  assign data     = cfg.eight ? sh[7:0] : {1'b0, sh[6:0]};
  assign par_bit  = sh[par_idx];
  assign stop_bit = sh[n_bits - 4'd1];
  assign perr_n   = cfg.pen & ((^data ^ par_bit) != cfg.ohel);

  assign btu = ((state == START) && (cnt == (cfg.k >> 1))) ||
               ((state == SHIFT) && (cnt == (cfg.k - 1'b1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cfg   <= '0;
      cnt   <= '0;
      bcnt  <= '0;
      sh    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt  <= '0;
          bcnt <= '0;
          if (!rx_s) begin
            cfg   <= '{k: baud_k, eight: eight, pen: pen, ohel: ohel};
            state <= START;
          end
        end
        START: begin
          bcnt <= '0;
          if (btu) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (btu) begin
            cnt      <= '0;
            sh[bcnt] <= rx_s;
            bcnt     <= bcnt + 4'd1;
            if (bcnt + 4'd1 == n_bits) state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= stop_bit ? IDLE : BRK;
        BRK:  if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A frame completing in the same cycle as a read takes precedence over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data <= '0;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (state == DONE) begin
      rx_data <= data;
      rxrdy   <= 1'b1;
      ferr    <= ~stop_bit;
      perr    <= perr_n;
      ovf     <= rxrdy & ~rd;
    end else if (rd) begin
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end
  end

endmodule
